// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, tenure default, FSM encoding.
// Optional tenure limit is enabled by defining ARB_TIMEOUT_EN.
package rr_arbiter8_pkg;
  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int DEF_HOLD_MAX = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter8_prio_enc.sv
// Rotating priority encoder: first set request at or above ptr, wrapping 7 -> 0.
module rr_prio_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);
  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest set bit wins last.
  always_comb begin
    idx  = ptr;
    cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

  assign any    = |req;
  assign onehot = any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with held grants, registered one-hot grant and mux select.
// Define ARB_TIMEOUT_EN to bound tenure at HOLD_MAX cycles and pulse timeout on revocation.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic             timeout
);
  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic             owner_req;
  logic             release_now;
  logic [SEL_W-1:0] enc_ptr;
  logic             enc_any;
  logic [SEL_W-1:0] enc_idx;
  logic [N_REQ-1:0] enc_onehot;

  assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire;

  assign expire      = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_now = (state_q == ARB_GRANT) && (!owner_req || expire);
  assign timeout     = timeout_q;
`else
  assign release_now = (state_q == ARB_GRANT) && !owner_req;
  assign timeout     = 1'b0;
`endif

  // While granted, the only use of the encoder is the handoff, which scans from the
  // post-release pointer so the releasing owner becomes lowest priority.
  assign enc_ptr = (state_q == ARB_GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

  rr_prio_enc8 u_enc (
    .req    (req),
    .ptr    (enc_ptr),
    .any    (enc_any),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    if (state_q == ARB_GRANT && !release_now) begin
`ifdef ARB_TIMEOUT_EN
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end else begin
      if (release_now) begin
        ptr_d = enc_ptr;
`ifdef ARB_TIMEOUT_EN
        timeout_d = owner_req;
`endif
      end
      if (enc_any) begin
        state_d     = ARB_GRANT;
        gnt_d       = enc_onehot;
        sel_d       = enc_idx;
        gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end else begin
        // sel keeps the last owner so the mux path does not toggle while idle.
        state_d     = ARB_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign sel       = sel_q;
endmodule
